// File: rtl/core_pkg.sv
// core_pkg: shared phase encoding, opcode constants and opcode classes for the 16-bit core
package core_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;
  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_STORE = 4'b1001;
  localparam logic [3:0] OP_JUMP  = 4'b1010;
  localparam logic [3:0] OP_BEQ   = 4'b1011;
  localparam logic [3:0] OP_HALT  = 4'b1111;
  typedef enum logic [2:0] {
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_JUMP,
    CL_BEQ,
    CL_NOP,
    CL_HALT
  } op_class_e;
endpackage

// File: rtl/op_class_decode.sv
// op_class_decode: opcode to instruction class, shared with the control unit
module op_class_decode
  import core_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_e  op_class
);
  always_comb
    op_class = !opcode[3]          ? CL_ALU   :
               opcode == OP_LOAD   ? CL_LOAD  :
               opcode == OP_STORE  ? CL_STORE :
               opcode == OP_JUMP   ? CL_JUMP  :
               opcode == OP_BEQ    ? CL_BEQ   :
               opcode == OP_HALT   ? CL_HALT  : CL_NOP;
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: fetch/decode/exec/mem/wb phase FSM with memory handshakes and retire counter
module multicycle_sequencer
  import core_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_wr,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_wr_en,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  op_class_e        op_class;
  logic             retire;
  op_class_decode u_dec (.opcode(opcode), .op_class(op_class));
  always_ff @(posedge clk)
    if (rst) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    imem_req  = 1'b0;
    ir_wr     = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_wr_en = 1'b0;
    case (state_q)
      S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        imem_req = 1'b1;
        ir_wr    = imem_ack;
        pc_inc   = imem_ack;
        state_d  = imem_ack ? S_DECODE : S_FETCH;
      end
      S_DECODE: state_d = op_class == CL_HALT ? S_HALT : S_EXEC;
      S_EXEC: begin
        pc_load = op_class == CL_JUMP || (op_class == CL_BEQ && zero);
        retire  = op_class inside {CL_JUMP, CL_BEQ, CL_NOP};
        state_d = op_class inside {CL_LOAD, CL_STORE} ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = op_class == CL_STORE;
        retire   = dmem_ack && op_class == CL_STORE;
        state_d  = dmem_ack ? S_WB : S_MEM;
      end
      S_WB: begin
        reg_wr_en = 1'b1;
        retire    = 1'b1;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    // the retire cycle is the instruction boundary where run is sampled
    if (retire) state_d = run ? S_FETCH : S_IDLE;
    retired_d = retired_q + CNT_W'(retire);
  end
  assign state   = state_q;
  assign halted  = state_q == S_HALT;
  assign retired = retired_q;
endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle phase controller for the 16-bit RISC core. It steps each instruction through fetch, decode, execute, memory and writeback. It also handshakes with instruction and data memory, and gates the write and strobe outputs of the combinational control unit so that each one fires only in its phase. It sits between the program counter / instruction register and the control unit, and owns the only retired-instruction counter in the core.

## Interface
- CNT_W, 16, width of retired-instruction counter
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  enable; sampled only at instruction boundaries
- opcode  in  4  IR[15:12], valid from DECODE onward
- zero  in  1  ALU compare result, valid in EXEC
- imem_ack  in  1  instruction word valid; sampled while imem_req=1
- dmem_ack  in  1  data access complete; sampled while dmem_req=1
- imem_req  out  1  instruction fetch request
- ir_wr  out  1  latch instruction register
- pc_inc  out  1  PC <= PC+1
- pc_load  out  1  PC <= jump/branch target
- dmem_req  out  1  data memory request
- dmem_we  out  1  data write qualifier (valid with dmem_req)
- reg_wr_en  out  1  register-file write strobe
- state  out  3  current phase, for debug
- halted  out  1  HALT state reached
- retired  out  CNT_W  instructions completed, wraps modulo 2^CNT_W

## Operation
- Opcode classes:
  - 0000–0111: ALU
  - 1000: LOAD
  - 1001: STORE
  - 1010: JUMP
  - 1011: BEQ
  - 1100–1110: NOP
  - 1111: HALT
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH: imem_req=1 every cycle until imem_ack=1. In the ack cycle, ir_wr=1 and pc_inc=1, then go to DECODE.
- DECODE: one cycle. HALT -> HALT. All other opcodes -> EXEC.
- EXEC: one cycle, then by class:
  - ALU -> WB.
  - LOAD/STORE -> MEM.
  - JUMP: pc_load=1, then retire.
  - BEQ: pc_load=zero, then retire.
  - NOP: retire.
- MEM: dmem_req=1 until dmem_ack=1. dmem_we=1 for STORE, 0 for LOAD.
  - LOAD ack -> WB.
  - STORE ack -> retire.
- WB: reg_wr_en=1 for exactly one cycle, then retire.
- Retire: retired increments by 1 in the final cycle of the instruction. Next state is FETCH if run=1, else IDLE.
- HALT: halted=1, all strobes 0, retired frozen. Only rst leaves HALT. The HALT instruction itself is not counted.
- run deasserted mid-instruction: the current instruction completes normally, then the sequencer goes to IDLE.
- All outputs are decoded from state plus registered inputs. No strobe is asserted outside its phase.

## Timing
- Reset values: state=IDLE; retired=0; all strobes, requests, dmem_we and halted = 0.
- rst has priority over every transition, including mid-handshake. Outstanding requests drop in the cycle after reset is sampled.
- Zero-wait memory (ack in the first request cycle), cycles per instruction:
  - ALU 4
  - LOAD 5
  - STORE 4
  - JUMP/BEQ/NOP 3
  - HALT reached 2 cycles after FETCH entry
- Each memory wait cycle adds 1 cycle.
- imem_req and dmem_req stay high and stable until ack. An ack sampled while the corresponding request is low is ignored.
- Back-to-back: with run=1, FETCH of the next instruction begins in the cycle after the retire cycle. There are no bubbles beyond the phase count.
- retired wrap: from all-ones, the next retire yields 0.

## Structure
- Shared package core_pkg holds:
  - state encoding constants
  - opcode constants (OP_LOAD=4'b1000, OP_STORE, OP_JUMP, OP_BEQ, OP_HALT)
  - opcode class encoding
- One natural sub-module: op_class_decode, combinational opcode -> class. It is shared with the control unit so both agree on classes.
- The FSM and retired counter live in this module.

## Test plan
- Reset, then run=1, ALU opcode 0010, zero-wait acks -> states FETCH, DECODE, EXEC, WB. reg_wr_en high for 1 cycle. retired=1 after 4 cycles.
- LOAD 1000 with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then WB. Total 8 cycles, retired +1.
- BEQ 1011: zero=1 -> pc_load=1 in EXEC. zero=0 -> pc_load stays 0. Both cases take 3 cycles.
- HALT 1111 -> halted=1 two cycles after FETCH entry. Strobes stay 0 and retired is unchanged for 20 cycles; rst -> IDLE, halted=0.
- rst asserted during MEM wait of a STORE -> next cycle state=IDLE, dmem_req=0, retired=0.
- CNT_W=4, run held high, 16 NOP 1100 instructions -> retired wraps to 0. Drop run during the 17th instruction -> it completes (retired=1), then IDLE.
